// File: rtl/parity_pkg.sv
// Shared parity types and helpers for the parity stream blocks.
package parity_pkg;

  typedef enum logic {
    MODE_GEN = 1'b0,
    MODE_CHK = 1'b1
  } mode_e;

  localparam int unsigned MaxDataW = 64;

  // Callers zero-extend narrower words; the padding bits do not change the result.
  function automatic logic calc_parity(input logic [MaxDataW-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction of a data word.
module parity_tree #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Streaming parity generator/checker with a single registered output stage
// and a saturating mismatch counter.
module parity_stream_gen_chk
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 odd_mode,
  input  logic                 chk_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_parity,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky,
  input  logic                 err_clr
);

  localparam logic [ERR_CNT_W-1:0] ErrCntMax = '1;

  logic                 data_par;
  logic                 p_calc;
  logic                 mismatch;
  logic                 accept;
  mode_e                mode;

  logic                 out_valid_q,  out_valid_d;
  logic [DATA_W-1:0]    out_data_q,   out_data_d;
  logic                 out_parity_q, out_parity_d;
  logic                 out_err_q,    out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,    err_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  parity_tree #(
    .DATA_W(DATA_W)
  ) u_parity_tree (
    .data  (in_data),
    .parity(data_par)
  );

  assign mode     = mode_e'(chk_mode);
  assign p_calc   = data_par ^ odd_mode;
  assign mismatch = data_par ^ in_parity ^ odd_mode;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_err_d    = out_err_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      if (mode == MODE_CHK) begin
        out_parity_d = in_parity;
        out_err_d    = mismatch;
      end else begin
        out_parity_d = p_calc;
        out_err_d    = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a mismatch arriving on the same edge.
    if (err_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (accept && (mode == MODE_CHK) && mismatch) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != ErrCntMax) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_parity_q <= 1'b0;
      out_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_parity_q <= out_parity_d;
      out_err_q    <= out_err_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_parity = out_parity_q;
  assign out_err    = out_err_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Scoreboard bench for parity_stream_gen_chk at DATA_W=4, ERR_CNT_W=2.
module tb_parity_stream_gen_chk;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          parity;
    logic          err;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          odd_mode = 1'b0;
  logic          chk_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_parity = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_parity;
  logic          out_err;
  logic [CW-1:0] err_cnt;
  logic          err_sticky;
  logic          err_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  beat_t exp_q[$];

  parity_stream_gen_chk #(
    .DATA_W   (DW),
    .ERR_CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .odd_mode  (odd_mode),
    .chk_mode  (chk_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_parity (in_parity),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_parity(out_parity),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic p, input logic odd, input logic chk,
                      input logic exp_par, input logic exp_err, input bit push);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    odd_mode  = odd;
    chk_mode  = chk;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (push) exp_q.push_back('{data: d, parity: exp_par, err: exp_err});
      @(posedge clk);
      #1;
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output handshake is matched against the queue head.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got data=%0h par=%0b err=%0b expected none",
                   out_data, out_parity, out_err);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_parity !== e.parity || out_err !== e.err) begin
            n_err++;
            $display("FAIL beat: got data=%0h par=%0b err=%0b expected data=%0h par=%0b err=%0b",
                     out_data, out_parity, out_err, e.data, e.parity, e.err);
          end
        end
      end
    end
  end

  logic [DW-1:0] t1_data [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b1111,
                                 4'b0101, 4'b1100, 4'b1110, 4'b1010};
  logic          t1_par  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int c0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_parity", 32'(out_parity), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_err_sticky", 32'(err_sticky), 0);
    rst_n = 1'b1;
    idle(1);

    // 1: gen even, back-to-back, no gaps
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(t1_data[i], 1'b0, 1'b0, 1'b0, t1_par[i], 1'b0, 1'b1);
    check("t1_cycles", 32'(cyc - c0), 8);
    idle(2);

    // 2: gen odd
    send(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send(4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // 3: chk even
    send(4'b0101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t3_err_cnt", 32'(err_cnt), 1);
    check("t3_sticky", 32'(err_sticky), 1);
    send(4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3_err_cnt_hold", 32'(err_cnt), 1);
    idle(2);

    // 4: back-pressure
    out_ready = 1'b0;
    send(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      send(4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t4_in_ready_low", 32'(in_ready), 0);
          check("t4_out_data_held", 32'(out_data), 32'h3);
          check("t4_out_valid_held", 32'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("t4_in_ready_high", 32'(in_ready), 1);
        @(posedge clk);
        #1 check("t4_next_loaded", 32'(out_data), 32'h8);
      end
    join
    idle(2);

    // 5: saturation then clear racing a mismatch
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t5_cleared", 32'(err_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      send(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      check($sformatf("t5_cnt_%0d", i), 32'(err_cnt), (i < 3) ? i + 1 : 3);
    end
    check("t5_sticky", 32'(err_sticky), 1);
    err_clr = 1'b1;
    send(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    err_clr = 1'b0;
    check("t5_clr_cnt", 32'(err_cnt), 0);
    check("t5_clr_sticky", 32'(err_sticky), 0);
    idle(2);

    // 6: reset with a held beat; it must never appear
    out_ready = 1'b0;
    send(4'b0110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("t6_pre_valid", 32'(out_valid), 1);
    check("t6_pre_cnt", 32'(err_cnt), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_cnt", 32'(err_cnt), 0);
    check("t6_rst_sticky", 32'(err_sticky), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(5);
    check("t6_no_beat", 32'(out_valid), 0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
